// File: rtl/cdb_arbiter_if.sv
// Writeback request ports and common data bus broadcast, bundled as one interface.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PTAG_W  = 6,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*PTAG_W-1:0] req_ptag;
    logic [NUM_REQ-1:0]        req_has_dst;
    logic [NUM_REQ*XLEN-1:0]   req_data;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_tag;

    logic                      cdb_valid;
    logic                      cdb_wake;
    logic [PTAG_W-1:0]         cdb_tag;
    logic [XLEN-1:0]           cdb_data;
    logic [ROB_W-1:0]          cdb_rob_tag;
    logic [SRC_W-1:0]          cdb_src;

    // Functional units side: offers results, observes grants and the broadcast.
    modport master (
        output req_valid, req_ptag, req_has_dst, req_data, req_rob_tag,
        input  req_ready,
        input  cdb_valid, cdb_wake, cdb_tag, cdb_data, cdb_rob_tag, cdb_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_ptag, req_has_dst, req_data, req_rob_tag,
        output req_ready,
        output cdb_valid, cdb_wake, cdb_tag, cdb_data, cdb_rob_tag, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one writeback port per
// cycle and broadcasts the registered result on the following cycle.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N_PHYS  = 64,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int PTAG_W = $clog2(N_PHYS);
    localparam int SRC_W  = $clog2(NUM_REQ);

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic               cdb_has_dst_q, cdb_has_dst_d;
    logic [PTAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]    cdb_data_q, cdb_data_d;
    logic [ROB_W-1:0]   cdb_rob_tag_q, cdb_rob_tag_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W:0]     scan_idx;
    logic [SRC_W:0]     next_ptr;

    logic [PTAG_W-1:0]  sel_tag;
    logic [XLEN-1:0]    sel_data;
    logic [ROB_W-1:0]   sel_rob_tag;
    logic               sel_has_dst;

    // Grant search: first valid port at or after rr_ptr, modulo NUM_REQ.
    // Depends only on req_valid, rr_ptr, flush and reset, so no ready loop exists.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (scan_idx >= (SRC_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (SRC_W+1)'(NUM_REQ);
            end
            if (!grant_any && bus.req_valid[scan_idx[SRC_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[SRC_W-1:0];
            end
        end
        if (flush || reset) begin
            grant_any = 1'b0;
        end
        grant = '0;
        grant[grant_idx] = grant_any;
    end

    // Payload mux: one-hot OR of the granted port's fields.
    always_comb begin
        sel_tag     = '0;
        sel_data    = '0;
        sel_rob_tag = '0;
        sel_has_dst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_tag     = sel_tag     | bus.req_ptag[i*PTAG_W +: PTAG_W];
                sel_data    = sel_data    | bus.req_data[i*XLEN +: XLEN];
                sel_rob_tag = sel_rob_tag | bus.req_rob_tag[i*ROB_W +: ROB_W];
                sel_has_dst = sel_has_dst | bus.req_has_dst[i];
            end
        end
    end

    // Next state: load the winner and advance the pointer past it; otherwise hold.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        cdb_valid_d   = grant_any;
        cdb_has_dst_d = cdb_has_dst_q;
        cdb_tag_d     = cdb_tag_q;
        cdb_data_d    = cdb_data_q;
        cdb_rob_tag_d = cdb_rob_tag_q;
        cdb_src_d     = cdb_src_q;
        next_ptr      = {1'b0, grant_idx} + (SRC_W+1)'(1);
        if (next_ptr == (SRC_W+1)'(NUM_REQ)) begin
            next_ptr = '0;
        end
        if (grant_any) begin
            cdb_has_dst_d = sel_has_dst;
            cdb_tag_d     = sel_tag;
            cdb_data_d    = sel_data;
            cdb_rob_tag_d = sel_rob_tag;
            cdb_src_d     = grant_idx;
            rr_ptr_d      = next_ptr[SRC_W-1:0];
        end
    end

    // State register with synchronous reset; outputs come straight from flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            rr_ptr_q      <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_has_dst_q <= 1'b0;
            cdb_tag_q     <= '0;
            cdb_data_q    <= '0;
            cdb_rob_tag_q <= '0;
            cdb_src_q     <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_has_dst_q <= cdb_has_dst_d;
            cdb_tag_q     <= cdb_tag_d;
            cdb_data_q    <= cdb_data_d;
            cdb_rob_tag_q <= cdb_rob_tag_d;
            cdb_src_q     <= cdb_src_d;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_wake    = cdb_valid_q & cdb_has_dst_q;
    assign bus.cdb_tag     = cdb_tag_q;
    assign bus.cdb_data    = cdb_data_q;
    assign bus.cdb_rob_tag = cdb_rob_tag_q;
    assign bus.cdb_src     = cdb_src_q;
endmodule
